// File: rtl/sys_clk_rst_gen_if.sv
// ----------------------------------------------------------------------------
// sys_clk_rst_gen_if
//   Bundle of clock/reset signals that sys_clk_rst_gen hands to the SoC core.
//
//   clk_div_o     divided system clock (10 MHz from 50 MHz by default)
//   clk_div_en_o  one reference-cycle strobe, high just before each clk_div_o rise
//   locked_o      divided clock stable
//   sys_rst_o     active-high system reset, aligned to clk_div_o falling edges
//   push_db_o     debounced push button level
//   rst_cause_o   01 = board reset, 10 = soft reset
//
//   master: the generator (drives everything)
//   slave : the core side (observes everything)
// ----------------------------------------------------------------------------
interface sys_clk_rst_gen_if;
    logic       clk_div_o;
    logic       clk_div_en_o;
    logic       locked_o;
    logic       sys_rst_o;
    logic       push_db_o;
    logic [1:0] rst_cause_o;

    modport master (
        output clk_div_o,
        output clk_div_en_o,
        output locked_o,
        output sys_rst_o,
        output push_db_o,
        output rst_cause_o
    );

    modport slave (
        input clk_div_o,
        input clk_div_en_o,
        input locked_o,
        input sys_rst_o,
        input push_db_o,
        input rst_cause_o
    );
endinterface

// File: rtl/sys_clk_rst_gen.sv
// ----------------------------------------------------------------------------
// sys_clk_rst_gen
//   Clock/reset front end for the SoC core.
//   - Divides clk_50M by CLK_DIV into a registered, glitch-free clk_div_o and
//     a matching clock-enable strobe for logic that stays on clk_50M.
//   - Sequences reset: LOCK_PERIODS divided periods until locked_o, then
//     RST_HOLD_PERIODS more with sys_rst_o held high. sys_rst_o only moves on
//     clk_div_o falling edges (apart from asynchronous assertion by reset_btn).
//   - Debounces push_btn; each new debounced press while running re-asserts
//     sys_rst_o for RST_HOLD_PERIODS periods without dropping locked_o.
//
// Ports
//   clk_50M    in   50 MHz reference clock
//   reset_btn  in   board reset, asynchronous, active-low
//   push_btn   in   raw soft-reset button, asynchronous, active-high
//   sys_if     master modport of sys_clk_rst_gen_if (all outputs)
// ----------------------------------------------------------------------------
module sys_clk_rst_gen #(
    parameter int CLK_DIV          = 5,
    parameter int LOCK_PERIODS     = 8,
    parameter int RST_HOLD_PERIODS = 16,
    parameter int DEBOUNCE_CYCLES  = 50000
) (
    input  logic              clk_50M,
    input  logic              reset_btn,
    input  logic              push_btn,
    sys_clk_rst_gen_if.master sys_if
);

    localparam int DIV_W  = (CLK_DIV > 1)          ? $clog2(CLK_DIV)          : 1;
    localparam int LOCK_W = (LOCK_PERIODS > 1)     ? $clog2(LOCK_PERIODS)     : 1;
    localparam int HOLD_W = (RST_HOLD_PERIODS > 1) ? $clog2(RST_HOLD_PERIODS) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1)  ? $clog2(DEBOUNCE_CYCLES)  : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_PERIODS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_PERIODS - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RUN,
        SOFT
    } state_t;

    // ------------------------------------------------------------------------
    // Clock divider
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic             clk_div_q;
    logic             clk_div_en_q;
    logic             fall_edge;

    always_comb begin
        // NOTE: give every always_comb output a default first so no path
        // leaves it unassigned (an unassigned path infers a latch).
        cnt_next = cnt + DIV_W'(1);
        if (cnt == DIV_LAST) begin
            cnt_next = '0;
        end
    end

    // The edge on which clk_div_o drops; the reset sequencer moves only here,
    // which keeps sys_rst_o aligned to divided-clock falling edges.
    assign fall_edge = (cnt_next == DIV_HALF);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            cnt          <= DIV_LAST;
            clk_div_q    <= 1'b0;
            clk_div_en_q <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            clk_div_q    <= (cnt_next < DIV_HALF);
            clk_div_en_q <= (cnt_next == DIV_LAST);
        end
    end

    // ------------------------------------------------------------------------
    // Push button synchronizer and debounce
    // ------------------------------------------------------------------------
    logic [1:0]      sync_q;
    logic            push_sync;
    logic [DB_W-1:0] db_cnt;
    logic            push_db_q;
    logic            db_rise;

    assign push_sync = sync_q[1];

    // Single-cycle pulse on the edge where the debounced level goes 0 -> 1.
    assign db_rise = push_sync && !push_db_q && (db_cnt == DB_LAST);

    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            sync_q    <= 2'b00;
            db_cnt    <= '0;
            push_db_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], push_btn};
            if (push_sync == push_db_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt    <= '0;
                push_db_q <= push_sync;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reset sequencer
    // ------------------------------------------------------------------------
    state_t            state;
    logic [LOCK_W-1:0] lock_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              pending;
    logic              locked_q;
    logic              sys_rst_q;
    logic [1:0]        rst_cause_q;

    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            state       <= WAIT_LOCK;
            lock_cnt    <= '0;
            hold_cnt    <= '0;
            pending     <= 1'b0;
            locked_q    <= 1'b0;
            sys_rst_q   <= 1'b1;
            rst_cause_q <= 2'b01;
        end else begin
            // Presses seen outside RUN are dropped; a held button cannot
            // re-arm because db_rise needs a fresh 0 -> 1 transition.
            if (db_rise && state == RUN) begin
                pending <= 1'b1;
            end

            if (fall_edge) begin
                case (state)
                    WAIT_LOCK: begin
                        if (lock_cnt == LOCK_LAST) begin
                            locked_q <= 1'b1;
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end else begin
                            lock_cnt <= lock_cnt + LOCK_W'(1);
                        end
                    end
                    HOLD, SOFT: begin
                        if (hold_cnt == HOLD_LAST) begin
                            sys_rst_q <= 1'b0;
                            state     <= RUN;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    RUN: begin
                        // Consuming the request wins over a same-edge press.
                        if (pending) begin
                            sys_rst_q   <= 1'b1;
                            rst_cause_q <= 2'b10;
                            pending     <= 1'b0;
                            hold_cnt    <= '0;
                            state       <= SOFT;
                        end
                    end
                    default: state <= WAIT_LOCK;
                endcase
            end
        end
    end

    assign sys_if.clk_div_o    = clk_div_q;
    assign sys_if.clk_div_en_o = clk_div_en_q;
    assign sys_if.locked_o     = locked_q;
    assign sys_if.sys_rst_o    = sys_rst_q;
    assign sys_if.push_db_o    = push_db_q;
    assign sys_if.rst_cause_o  = rst_cause_q;

endmodule

// File: tb/tb_sys_clk_rst_gen.sv
// ----------------------------------------------------------------------------
// tb_sys_clk_rst_gen
//   Drives two generators (CLK_DIV = 5 and 4, DEBOUNCE_CYCLES = 16) from the
//   same clock, board reset and push button, and compares every output each
//   cycle against a timeline model: edge n after release sits at divider
//   phase (n-1) % CLK_DIV, reset state follows from the number of falling
//   edges seen, and the debounced level flips once the last DEBOUNCE_CYCLES
//   synchronized samples all disagree with it.
// ----------------------------------------------------------------------------
module tb_sys_clk_rst_gen;

    localparam int LOCK = 8;
    localparam int HOLD = 16;
    localparam int DEB  = 16;

    logic clk_50M   = 1'b0;
    logic reset_btn = 1'b0;
    logic push_btn  = 1'b0;

    always #10 clk_50M = ~clk_50M;

    sys_clk_rst_gen_if if5 ();
    sys_clk_rst_gen_if if4 ();

    sys_clk_rst_gen #(
        .CLK_DIV(5), .LOCK_PERIODS(LOCK), .RST_HOLD_PERIODS(HOLD), .DEBOUNCE_CYCLES(DEB)
    ) dut5 (
        .clk_50M(clk_50M), .reset_btn(reset_btn), .push_btn(push_btn), .sys_if(if5)
    );

    sys_clk_rst_gen #(
        .CLK_DIV(4), .LOCK_PERIODS(LOCK), .RST_HOLD_PERIODS(HOLD), .DEBOUNCE_CYCLES(DEB)
    ) dut4 (
        .clk_50M(clk_50M), .reset_btn(reset_btn), .push_btn(push_btn), .sys_if(if4)
    );

    // Observed outputs: [0] clk_div [1] en [2] locked [3] sys_rst [4] push_db [6:5] cause
    logic [6:0] obs [2];
    assign obs[0] = {if5.rst_cause_o, if5.push_db_o, if5.sys_rst_o, if5.locked_o,
                     if5.clk_div_en_o, if5.clk_div_o};
    assign obs[1] = {if4.rst_cause_o, if4.push_db_o, if4.sys_rst_o, if4.locked_o,
                     if4.clk_div_en_o, if4.clk_div_o};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 25)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         n;          // clk_50M edges since reset release
    int         nf [2];     // falling edges of the divided clock so far
    int         end_f [2];  // sys_rst_o is high while nf < end_f
    bit         pend [2];
    logic [1:0] cause [2];
    bit         pipe [2];   // button samples still inside the synchronizer
    bit         win [$];    // last DEB synchronized samples
    bit         m_db;

    function automatic int div_of(input int i);
        return (i == 0) ? 5 : 4;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 2; i++) begin
            nf[i]    = 0;
            end_f[i] = LOCK + HOLD;
            pend[i]  = 1'b0;
            cause[i] = 2'b01;
        end
        pipe[0] = 1'b0;
        pipe[1] = 1'b0;
        win.delete();
        m_db = 1'b0;
    endtask

    task automatic model_edge(input bit btn);
        bit used, all_diff, rise;
        n++;
        used    = pipe[0];
        pipe[0] = pipe[1];
        pipe[1] = btn;
        win.push_back(used);
        if (win.size() > DEB) void'(win.pop_front());
        rise = 1'b0;
        if (win.size() == DEB) begin
            all_diff = 1'b1;
            foreach (win[k]) if (win[k] == m_db) all_diff = 1'b0;
            if (all_diff) begin
                rise = !m_db;
                m_db = !m_db;
            end
        end
        for (int i = 0; i < 2; i++) begin
            int  d;
            bit  run_before, consumed;
            d          = div_of(i);
            run_before = (nf[i] >= end_f[i]);
            consumed   = 1'b0;
            if ((n - 1) % d == d / 2) begin
                nf[i]++;
                if (run_before && pend[i]) begin
                    end_f[i] = nf[i] + HOLD;
                    cause[i] = 2'b10;
                    pend[i]  = 1'b0;
                    consumed = 1'b1;
                end
            end
            if (!consumed && rise && run_before) pend[i] = 1'b1;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int         d;
            logic [6:0] e;
            d = div_of(i);
            e = '0;
            if (n > 0) begin
                e[0] = ((n - 1) % d) < d / 2;
                e[1] = ((n - 1) % d) == d - 1;
            end
            e[2]   = nf[i] >= LOCK;
            e[3]   = nf[i] < end_f[i];
            e[4]   = m_db;
            e[6:5] = cause[i];
            check($sformatf("div%0d clk_div", d), obs[i][0], e[0]);
            check($sformatf("div%0d clk_div_en", d), obs[i][1], e[1]);
            check($sformatf("div%0d locked", d), obs[i][2], e[2]);
            check($sformatf("div%0d sys_rst", d), obs[i][3], e[3]);
            check($sformatf("div%0d push_db", d), obs[i][4], e[4]);
            check($sformatf("div%0d rst_cause", d), obs[i][6:5], e[6:5]);
        end
    endtask

    // ---------------- event tracking ----------------
    logic [6:0] prev [2];
    int lock_edge [2], first_fall [2], rise_edge [2], fall_edge [2], rise_cnt [2];
    int db_rise_edge;

    task automatic track_reset();
        for (int i = 0; i < 2; i++) begin
            prev[i]       = obs[i];
            lock_edge[i]  = -1;
            first_fall[i] = -1;
        end
    endtask

    task automatic monitor();
        for (int i = 0; i < 2; i++) begin
            logic [6:0] cur;
            cur = obs[i];
            if (cur[3] != prev[i][3]) begin
                check($sformatf("div%0d sys_rst on clk_div fall", div_of(i)),
                      {prev[i][0], cur[0]}, 2'b10);
                if (cur[3]) begin
                    rise_edge[i] = n;
                    rise_cnt[i]++;
                end else begin
                    fall_edge[i] = n;
                    if (first_fall[i] < 0) first_fall[i] = n;
                end
            end
            if (cur[2] && !prev[i][2] && lock_edge[i] < 0) lock_edge[i] = n;
            if (i == 0 && cur[4] && !prev[i][4]) db_rise_edge = n;
            prev[i] = cur;
        end
    endtask

    // One clk_50M cycle: called at a negedge, leaves at the next negedge.
    task automatic cycle(input bit btn);
        push_btn = btn;
        @(posedge clk_50M);
        model_edge(btn);
        @(negedge clk_50M);
        compare_all();
        monitor();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  p, start_cnt, len;
        bit  lvl, found;

        for (int i = 0; i < 2; i++) begin
            rise_cnt[i]  = 0;
            rise_edge[i] = 0;
            fall_edge[i] = 0;
        end
        db_rise_edge = -1;
        model_reset();
        repeat (3) @(negedge clk_50M);
        compare_all();                       // values held in reset
        reset_btn = 1'b1;                    // edge 0 is this release
        track_reset();

        // Button pressed during WAIT_LOCK/HOLD, released in RUN: no soft reset.
        repeat (20) cycle(1'b0);
        repeat (110) cycle(1'b1);
        check("lock edge div5", lock_edge[0], 38);
        check("rst release edge div5", first_fall[0], 118);
        check("lock edge div4", lock_edge[1], 31);
        check("rst release edge div4", first_fall[1], 95);
        repeat (40) cycle(1'b0);
        check("no soft reset after early press", rise_cnt[0], 0);

        // 10-cycle glitch is filtered.
        repeat (10) cycle(1'b1);
        repeat (30) cycle(1'b0);
        check("glitch push_db", obs[0][4], 1'b0);
        check("glitch sys_rst", obs[0][3], 1'b0);

        // 40-cycle press: debounced after 18 cycles, one soft reset.
        p = n;
        repeat (40) cycle(1'b1);
        check("debounce latency", db_rise_edge - p, 18);
        repeat (120) cycle(1'b0);
        check("soft reset length div5", fall_edge[0] - rise_edge[0], HOLD * 5);
        check("soft reset length div4", fall_edge[1] - rise_edge[1], HOLD * 4);
        check("soft cause", obs[0][6:5], 2'b10);
        check("locked through soft", obs[0][2], 1'b1);

        // Button held across the end of SOFT: exactly one reset.
        start_cnt = rise_cnt[0];
        repeat (200) cycle(1'b1);
        repeat (40) cycle(1'b0);
        check("held press single reset", rise_cnt[0] - start_cnt, 1);

        // Random press/release runs.
        repeat (40) begin
            len = $urandom_range(1, 45);
            lvl = 1'($urandom_range(0, 1));
            repeat (len) cycle(lvl);
        end

        // Board reset in the 5th period of a soft reset.
        repeat (120) cycle(1'b0);
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (end_f[0] > nf[0] && nf[0] == end_f[0] - HOLD + 4) begin
                found = 1'b1;
                break;
            end
            cycle(k < 40);
        end
        check("reached 5th soft period", found, 1'b1);
        push_btn = 1'b0;
        @(posedge clk_50M);
        #3 reset_btn = 1'b0;
        #1;
        model_reset();
        compare_all();                       // async reset values, same cycle
        @(negedge clk_50M);
        reset_btn = 1'b1;
        track_reset();
        repeat (130) cycle(1'b0);
        check("relock edge div5", lock_edge[0], 38);
        check("re-release edge div5", first_fall[0], 118);
        check("cause after board reset", obs[0][6:5], 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
